shape1_reader: RTL and testbench

SHAPE1_READER -- requirements
Module: shape1_reader

---
 rtl/shape_pkg.sv | 22 ++
 rtl/shape1_reader.sv | 128 ++++++++++++
 tb/tb_shape1_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shape_pkg.sv
// rtl/shape_pkg.sv - shared constants, state encoding and orientation codes for shape ROM readers
package shape_pkg;

  // Frame geometry of every shape ROM.
  localparam int DEF_SHAPE_ROWS = 60;
  localparam int DEF_SHAPE_COLS = 51;

  // Reader FSM: fetch a row address, wait one cycle for ROM data, shift pixels out.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHIFT = 2'd3
  } reader_state_t;

  // Orientation codes; code 3 has no image and the ROM answers with zeros.
  localparam logic [1:0] ORIENT_0 = 2'd0;
  localparam logic [1:0] ORIENT_1 = 2'd1;
  localparam logic [1:0] ORIENT_2 = 2'd2;
  localparam logic [1:0] ORIENT_3 = 2'd3;

endpackage

// File: rtl/shape1_reader.sv
// rtl/shape1_reader.sv - reads a shape ROM row by row and streams it out one pixel per handshake
module shape1_reader
  import shape_pkg::*;
#(
  parameter int SHAPE_ROWS = DEF_SHAPE_ROWS,
  parameter int SHAPE_COLS = DEF_SHAPE_COLS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            orientation,
  output logic                  busy,
  output logic                  done,
  output logic [5:0]            rom_address,
  output logic [1:0]            rom_orientation,
  input  logic [SHAPE_COLS-1:0] rom_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_on,
  output logic [5:0]            pix_x,
  output logic [5:0]            pix_y,
  output logic                  pix_last
);

  // Counters are 6 bits because the pixel coordinate ports are; both maxima fit.
  localparam logic [5:0] ROW_MAX = 6'(SHAPE_ROWS - 1);
  localparam logic [5:0] COL_MAX = 6'(SHAPE_COLS - 1);

  reader_state_t         state;
  reader_state_t         state_next;
  logic [5:0]            row;
  logic [5:0]            col;
  logic [SHAPE_COLS-1:0] row_buf;
  logic                  accept;
  logic                  handshake;
  logic                  frame_end;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so it is ignored while busy.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    handshake  = 1'b0;
    frame_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: state_next = ST_WAIT;
      ST_WAIT:  state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (pix_ready) begin
          handshake = 1'b1;
          if (col == COL_MAX) begin
            if (row == ROW_MAX) begin
              frame_end  = 1'b1;
              state_next = ST_IDLE;
            end else begin
              state_next = ST_FETCH;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Row/column counters, latched orientation and the row buffer; the buffer shifts left so
  // its MSB is always the pixel for the current column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row             <= '0;
      col             <= '0;
      row_buf         <= '0;
      rom_orientation <= ORIENT_0;
    end else begin
      if (accept) begin
        row             <= '0;
        col             <= '0;
        rom_orientation <= orientation;
      end
      if (state == ST_WAIT) begin
        row_buf <= rom_data;
        col     <= '0;
      end
      if (handshake) begin
        row_buf <= row_buf << 1;
        if (col == COL_MAX) begin
          if (row != ROW_MAX) begin
            row <= row + 6'd1;
          end
        end else begin
          col <= col + 6'd1;
        end
      end
    end
  end

  // Done pulses in the cycle after the final pixel handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= frame_end;
    end
  end

  // Row only changes on entry to FETCH, so the address is stable through FETCH and WAIT.
  assign rom_address = row;
  assign busy        = (state != ST_IDLE);
  assign pix_valid   = (state == ST_SHIFT);
  assign pix_on      = pix_valid & row_buf[SHAPE_COLS-1];
  assign pix_x       = pix_valid ? col : 6'd0;
  assign pix_y       = pix_valid ? row : 6'd0;
  assign pix_last    = pix_valid && (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: tb/tb_shape1_reader.sv
// tb/tb_shape1_reader.sv - randomized scoreboard bench for shape1_reader with a shape1 ROM model
module tb_shape1_reader;
  import shape_pkg::*;

  localparam int ROWS = DEF_SHAPE_ROWS;
  localparam int COLS = DEF_SHAPE_COLS;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      orientation = 2'd0;
  logic            pix_ready = 1'b0;
  logic            busy;
  logic            done;
  logic [5:0]      rom_address;
  logic [1:0]      rom_orientation;
  logic [COLS-1:0] rom_data = '0;
  logic            pix_valid;
  logic            pix_on;
  logic [5:0]      pix_x;
  logic [5:0]      pix_y;
  logic            pix_last;

  typedef struct packed {
    logic [1:0] o;
    logic       last;
    logic       on;
    logic [5:0] y;
    logic [5:0] x;
  } pix_t;

  pix_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   hs_total = 0;
  int   done_seen = 0;
  int   done_expected = 0;
  int   last_y = -1;
  bit   stall_en = 1'b0;
  bit   done_pending = 1'b0;
  bit   hold_valid = 1'b0;
  pix_t held;

  shape1_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .orientation(orientation),
    .busy(busy), .done(done), .rom_address(rom_address), .rom_orientation(rom_orientation),
    .rom_data(rom_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_on(pix_on),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  // Shape1 image: a vertical bar plus a horizontal band, placed differently per orientation.
  function automatic bit shape_bit(input logic [1:0] o, input int r, input int c);
    case (o)
      2'd0:    return (c == 25) || (r >= 15 && r <= 22);
      2'd1:    return (c == 6) || (c >= 23 && c <= 44 && r >= 8 && r <= 30);
      2'd2:    return (c == 25) || (r >= 37 && r <= 44);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [COLS-1:0] rom_row(input logic [1:0] o, input int r);
    logic [COLS-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) v = {v[COLS-2:0], shape_bit(o, r, c)};
    return v;
  endfunction

  // ROM partner: data appears one clock after address/orientation.
  always_ff @(posedge clk) rom_data <= rom_row(rom_orientation, int'(rom_address));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready, optionally throttled at random.
  initial forever begin
    @(posedge clk);
    #1;
    pix_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: pops the scoreboard on each handshake, checks stall stability and the done pulse.
  initial forever begin
    pix_t act;
    pix_t e;
    @(negedge clk);
    if (!rst_n) begin
      done_pending = 1'b0;
      hold_valid   = 1'b0;
    end else begin
      act = {rom_orientation, pix_last, pix_on, pix_y, pix_x};
      if (hold_valid) check("stall_hold", 32'({pix_valid, act}), 32'({1'b1, held}));
      if (done_pending || done) check("done_pulse", 32'(done), 32'(done_pending));
      if (done) done_seen++;
      done_pending = 1'b0;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_pixel: got %0h expected none at %0t", act, $time);
        end else begin
          e = exp_q.pop_front();
          check("pixel", 32'(act), 32'(e));
          done_pending = e.last;
        end
        hs_total++;
        last_y = int'(pix_y);
      end
      hold_valid = pix_valid && !pix_ready;
      held       = act;
    end
  end

  task automatic start_frame(input logic [1:0] o);
    pix_t e;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        e.o    = o;
        e.last = (x == COLS - 1) && (y == ROWS - 1);
        e.on   = shape_bit(o, y, x);
        e.y    = 6'(y);
        e.x    = 6'(x);
        exp_q.push_back(e);
      end
    end
    done_expected++;
    orientation = o;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 15000; n++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    compared++;
    mismatched++;
    $display("FAIL %s: done=0 expected a done pulse within 15000 cycles", name);
  endtask

  task automatic end_checks(input string name);
    @(posedge clk);
    #1;
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int n;
    logic [1:0] ro;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({busy, done, pix_valid, pix_on, pix_last, pix_x, pix_y,
                                rom_address, rom_orientation}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Orientation 0, free-flowing.
    stall_en = 1'b0;
    start_frame(2'd0);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done("o0_plain");
    end_checks("o0_plain");

    // Orientation 0 with random stalls.
    stall_en = 1'b1;
    start_frame(2'd0);
    wait_done("o0_stall");
    end_checks("o0_stall");

    // Second start at pixel 100 must be ignored.
    base = hs_total;
    start_frame(2'd0);
    n = 0;
    while (hs_total - base < 100 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    orientation = 2'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_restart", 32'(busy), 32'd1);
    wait_done("restart");
    end_checks("restart");

    // Reset in the middle of row 30.
    stall_en = 1'b0;
    last_y = -1;
    start_frame(2'd1);
    n = 0;
    while (last_y < 30 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", 32'({busy, done, pix_valid, pix_on, pix_last, pix_x, pix_y,
                                         rom_address, rom_orientation}), 32'd0);
    exp_q.delete();
    done_expected--;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("no_done_after_reset", 32'(done_seen), 32'(done_expected));
    check("idle_after_reset", 32'(busy), 32'd0);

    // Fresh frame, then orientation 3 started in the done cycle.
    start_frame(2'd0);
    wait_done("fresh");
    start_frame(2'd3);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done("o3");
    end_checks("o3");

    // Orientation 1 and 2 with stalls, then one random orientation.
    stall_en = 1'b1;
    start_frame(2'd1);
    wait_done("o1");
    end_checks("o1");
    start_frame(2'd2);
    wait_done("o2");
    end_checks("o2");
    ro = 2'($urandom_range(0, 3));
    start_frame(ro);
    wait_done("orand");
    end_checks("orand");

    check("done_count", 32'(done_seen), 32'(done_expected));
    check("handshake_total", 32'(hs_total), 32'(8 * ROWS * COLS + (hs_total % (ROWS * COLS))));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
